instr_assembler: RTL and testbench

INSTR_ASSEMBLER -- requirements
Module: instr_assembler

---
 rtl/rv_isa_pkg.sv | 44 ++++
 rtl/instr_pack.sv | 78 +++++++
 rtl/instr_assembler.sv | 112 +++++++++++
 tb/tb_instr_assembler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// -----------------------------------------------------------------------------
// rv_isa_pkg
// Shared RV32I definitions used by the instruction assembler and the
// immediate decoder: base opcode constants, the instruction-format enum and
// a helper that maps an opcode onto its format.
// No ports (package).
// -----------------------------------------------------------------------------
package rv_isa_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE    // opcode outside the supported RV32I subset
  } fmt_e;

  function automatic fmt_e opcode_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_LUI, OPC_AUIPC:            f = FMT_U;
      OPC_JAL:                       f = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: f = FMT_I;
      OPC_STORE:                     f = FMT_S;
      OPC_BRANCH:                    f = FMT_B;
      OPC_OP:                        f = FMT_R;
      default:                       f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational RV32I field packer. Places the supplied fields into the
// 32-bit encoding dictated by the opcode's format and flags unsupported
// opcodes. When the macro RANGE_CHECK_EN is defined, immediates that do not
// fit their format are also flagged (the word is still the truncated
// encoding); without it, immediates are silently truncated.
//
// Ports:
//   opcode [6:0], rd [4:0], funct3 [2:0], rs1 [4:0], rs2 [4:0],
//   funct7 [6:0], imm [31:0]  - instruction fields (imm is pre-shift)
//   instr [31:0]              - encoded word (0 for unsupported opcodes)
//   err                       - encoding error
// -----------------------------------------------------------------------------
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e fmt;
  logic fmt_err;
  logic range_err;

  assign fmt = opcode_fmt(opcode);

  always_comb begin
    instr   = 32'h0;
    fmt_err = 1'b0;
    case (fmt)
      FMT_U: instr = {imm[31:12], rd, opcode};
      FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      default: begin
        instr   = 32'h0;
        fmt_err = 1'b1;
      end
    endcase
  end

`ifdef RANGE_CHECK_EN
  // An immediate "fits" when every bit above the format's top bit is a copy
  // of that top bit. JALR is the exception: its offset is zero-extended here.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_U: range_err = |imm[11:0];
      FMT_J: range_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
      FMT_B: range_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_I: begin
        if (opcode == OPC_JALR) begin
          range_err = |imm[31:12];
        end else begin
          range_err = (imm[31:11] != {21{imm[11]}});
        end
      end
      FMT_S: range_err = (imm[31:11] != {21{imm[11]}});
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign err = fmt_err | range_err;

endmodule

// File: rtl/instr_assembler.sv
// -----------------------------------------------------------------------------
// instr_assembler
// Accepts a bundle of RV32I instruction fields over a valid/ready handshake,
// encodes it (via instr_pack) and presents the word from a single output
// register with valid/ready. One-cycle latency, full throughput. Also counts
// accepted bundles and erroneous words delivered downstream (both wrap).
// Optional immediate range checking is enabled with the macro RANGE_CHECK_EN
// (see instr_pack).
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - input bundle handshake
//   opcode, rd, funct3, rs1, rs2, funct7, imm - instruction fields
//   out_valid, out_ready - output word handshake
//   instr [31:0], err   - encoded word and its error flag (qualified by out_valid)
//   acc_cnt [15:0]      - accepted bundles
//   err_cnt [15:0]      - err=1 words taken by downstream
// -----------------------------------------------------------------------------
module instr_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] acc_cnt,
  output logic [15:0] err_cnt
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [15:0] acc_cnt_q, acc_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic [31:0] pack_instr;
  logic        pack_err;
  logic        accept;
  logic        drain;

  instr_pack u_pack (
    .opcode (opcode),
    .rd     (rd),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct7 (funct7),
    .imm    (imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  // The stage can take a bundle when empty or when its word leaves this
  // cycle. Gating with rst guarantees no bundle is consumed during reset.
  assign in_ready = (!out_valid_q || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    acc_cnt_d   = acc_cnt_q;
    err_cnt_d   = err_cnt_q;

    // A simultaneous accept and drain replaces the old word with the new one.
    if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = pack_instr;
      err_d       = pack_err;
      acc_cnt_d   = acc_cnt_q + 16'd1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end

    if (drain && err_q) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'h0;
      err_q       <= 1'b0;
      acc_cnt_q   <= 16'h0;
      err_cnt_q   <= 16'h0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      acc_cnt_q   <= acc_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;
  assign acc_cnt   = acc_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_assembler.sv
// -----------------------------------------------------------------------------
// tb_instr_assembler
// Self-checking bench for instr_assembler. Expected words come from a
// bit-level reference encoder and are queued on accept, then popped and
// compared when the DUT hands a word downstream. Counters are tracked by a
// bench-side model. Expectations follow RANGE_CHECK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_instr_assembler;

`ifdef RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [15:0] acc_cnt;
  logic [15:0] err_cnt;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] exp_acc;
  logic [15:0] exp_errc;
  int          checks;
  int          errors;
  bit          verbose;

  instr_assembler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .acc_cnt   (acc_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoder, written bit-field by bit-field with numeric range tests.
  function automatic exp_t ref_encode(input logic [6:0] o, input logic [4:0] d,
                                      input logic [2:0] f, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [6:0] f7,
                                      input logic [31:0] im);
    exp_t e;
    logic [31:0] w;
    logic bad;
    w = 32'h0;
    bad = 1'b0;
    w[6:0] = o;
    case (o)
      7'h37, 7'h17: begin
        w[31:12] = im[31:12]; w[11:7] = d;
        if (RC) bad = (im[11:0] != 12'h0);
      end
      7'h6F: begin
        w[31] = im[20]; w[30:21] = im[10:1]; w[20] = im[11]; w[19:12] = im[19:12];
        w[11:7] = d;
        if (RC) bad = ($signed(im) < -32'sd1048576) || ($signed(im) > 32'sd1048575) || im[0];
      end
      7'h67, 7'h03, 7'h13: begin
        w[31:20] = im[11:0]; w[19:15] = s1; w[14:12] = f; w[11:7] = d;
        if (RC) begin
          if (o == 7'h67) bad = (im > 32'h0000_0FFF);
          else bad = ($signed(im) < -32'sd2048) || ($signed(im) > 32'sd2047);
        end
      end
      7'h23: begin
        w[31:25] = im[11:5]; w[24:20] = s2; w[19:15] = s1; w[14:12] = f; w[11:7] = im[4:0];
        if (RC) bad = ($signed(im) < -32'sd2048) || ($signed(im) > 32'sd2047);
      end
      7'h63: begin
        w[31] = im[12]; w[30:25] = im[10:5]; w[24:20] = s2; w[19:15] = s1; w[14:12] = f;
        w[11:8] = im[4:1]; w[7] = im[11];
        if (RC) bad = ($signed(im) < -32'sd4096) || ($signed(im) > 32'sd4095) || im[0];
      end
      7'h33: begin
        w[31:25] = f7; w[24:20] = s2; w[19:15] = s1; w[14:12] = f; w[11:7] = d;
      end
      default: begin
        w = 32'h0;
        bad = 1'b1;
      end
    endcase
    e.instr = w;
    e.err = bad;
    return e;
  endfunction

  task automatic drive(input logic [6:0] o, input logic [4:0] d, input logic [2:0] f,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                       input logic [31:0] im);
    opcode = o; rd = d; funct3 = f; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  // One clock: handshakes are observed at the falling edge, then state is
  // checked 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_underflow: observed word 0x%08h expected no word", instr);
        end else begin
          e = sb_q.pop_front();
          check("sb_instr", instr, e.instr);
          check("sb_err", {31'h0, err}, {31'h0, e.err});
          if (e.err) exp_errc = exp_errc + 16'd1;
          if (verbose) $display("xfer instr=0x%08h err=%0d", instr, err);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_encode(opcode, rd, funct3, rs1, rs2, funct7, imm));
        exp_acc = exp_acc + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
      exp_acc = 16'h0;
      exp_errc = 16'h0;
    end
    check("acc_cnt", {16'h0, acc_cnt}, {16'h0, exp_acc});
    check("err_cnt", {16'h0, err_cnt}, {16'h0, exp_errc});
    check("out_valid", {31'h0, out_valid}, {31'h0, (sb_q.size() != 0)});
  endtask

  initial begin
    exp_t held;
    logic [6:0] opc_tab [0:10];
    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h7F, 7'h0B};
    checks = 0; errors = 0; verbose = 1'b1;
    exp_acc = 16'h0; exp_errc = 16'h0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 7'h0; rd = 5'h0; funct3 = 3'h0; rs1 = 5'h0; rs2 = 5'h0; funct7 = 7'h0; imm = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // LUI rd=5
    drive(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    tick();
    in_valid = 1'b0;
    check("lui_valid", {31'h0, out_valid}, 32'h1);
    check("lui_instr", instr, 32'h1234_52B7);
    check("lui_err", {31'h0, err}, 32'h0);
    tick();

    // OP-IMM rd=1, imm=-1
    drive(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
    tick();
    in_valid = 1'b0;
    check("opimm_instr", instr, 32'hFFF0_0093);
    check("opimm_err", {31'h0, err}, 32'h0);
    tick();

    // JAL rd=0, imm=8
    drive(7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0008);
    tick();
    in_valid = 1'b0;
    check("jal_instr", instr, 32'h0080_006F);
    check("jal_err", {31'h0, err}, 32'h0);
    tick();

    // BRANCH imm=3: misaligned, only an error with range checking
    drive(7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0003);
    tick();
    in_valid = 1'b0;
    check("br_instr", instr, 32'h0000_0163);
    check("br_err", {31'h0, err}, {31'h0, RC});
    tick();
    check("br_err_cnt", {16'h0, err_cnt}, {31'h0, RC});

    // Unsupported opcode
    drive(7'h7F, 5'd3, 3'd1, 5'd2, 5'd4, 7'd1, 32'h0000_0010);
    tick();
    in_valid = 1'b0;
    check("bad_instr", instr, 32'h0);
    check("bad_err", {31'h0, err}, 32'h1);
    tick();
    check("bad_err_cnt", {16'h0, err_cnt}, {31'h0, RC} + 32'h1);

    // Randomised traffic with random back-pressure
    for (int i = 0; i < 60; i++) begin
      opcode = opc_tab[$urandom_range(0, 10)];
      rd = 5'($urandom); funct3 = 3'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct7 = 7'($urandom);
      imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(12'($urandom)));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rand_drained", sb_q.size(), 32'h0);

    // Stall: word is held, nothing else accepted
    drive(7'h33, 5'd7, 3'd5, 5'd3, 5'd9, 7'h20, 32'h0);
    out_ready = 1'b0;
    tick();
    held = ref_encode(7'h33, 5'd7, 3'd5, 5'd3, 5'd9, 7'h20, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(7'h23, 5'd0, 3'd2, 5'(i), 5'd6, 7'd0, 32'(i * 4));
      tick();
      check("stall_in_ready", {31'h0, in_ready}, 32'h0);
      check("stall_instr", instr, held.instr);
      check("stall_acc", {16'h0, acc_cnt}, {16'h0, exp_acc});
    end
    // Release: one new word per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(7'h03, 5'(i + 1), 3'd2, 5'd8, 5'd0, 7'd0, 32'(i * 8));
      tick();
      check("b2b_valid", {31'h0, out_valid}, 32'h1);
      check("b2b_in_ready", {31'h0, in_ready}, 32'h1);
      check("b2b_instr", instr, ref_encode(7'h03, 5'(i + 1), 3'd2, 5'd8, 5'd0, 7'd0, 32'(i * 8)).instr);
    end
    in_valid = 1'b0;
    tick();

    // Reset during a stall discards the held word
    drive(7'h17, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCD_E000);
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rstst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rstst_acc", {16'h0, acc_cnt}, 32'h0);
    check("rstst_errc", {16'h0, err_cnt}, 32'h0);
    check("rstst_instr", instr, 32'h0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rstst_in_ready", {31'h0, in_ready}, 32'h1);

    // acc_cnt wrap
    verbose = 1'b0;
    drive(7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    repeat (65535) tick();
    check("wrap_ffff", {16'h0, acc_cnt}, 32'h0000_FFFF);
    tick();
    check("wrap_zero", {16'h0, acc_cnt}, 32'h0);
    in_valid = 1'b0;
    tick();
    tick();
    check("end_drained", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
